// File: rtl/im_stage_ctrl.sv
// im_stage_ctrl: IM pipeline stage controller.
// Non-memory instructions are written back after one cycle. Memory instructions
// stall upstream, run one data-memory access and then write back the result.
// Build option: define IM_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently ignoring the unused low address bits.
//
// state  | meaning
// IDLE   | accepting instructions; ALU results go straight to write-back
// ACCESS | data-memory access in flight on latched operands, waiting for dmem_ready
module im_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] O_in,
  input  logic [31:0] B_in,
  input  logic [1:0]  access_size_in,
  input  logic        rw_in,
  input  logic        mem_en_in,
  input  logic        memory_sign_extend_in,
  input  logic        res_data_sel_in,
  input  logic [4:0]  dest_reg_in,
  input  logic        write_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_write_en,
  output logic        misalign_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] o_q, o_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  size_q, size_d;
  logic        rw_q, rw_d;
  logic        sext_q, sext_d;
  logic        sel_q, sel_d;
  logic [4:0]  dest_q, dest_d;
  logic        wr_q, wr_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic        wb_write_en_q, wb_write_en_d;

  logic        trap;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

`ifdef IM_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;

  // Misaligned half (odd address) or word (any low bit set) memory access.
  assign trap = mem_en_in &&
                (((access_size_in == SZ_HALF) && O_in[0]) ||
                 ((access_size_in != SZ_HALF) && (access_size_in != SZ_BYTE) &&
                  (O_in[1:0] != 2'b00)));
  assign misalign_err = misalign_q;
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Byte-lane enables and replicated store data from the latched access.
  always_comb begin
    be    = 4'b1111;
    wdata = b_q;
    case (size_q)
      SZ_BYTE: begin
        be    = 4'b0001 << o_q[1:0];
        wdata = {4{b_q[7:0]}};
      end
      SZ_HALF: begin
        be    = o_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{b_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = b_q;
      end
    endcase
  end

  // Extract and extend the addressed byte/half of the read data.
  always_comb begin
    byte_sel  = dmem_rdata[{o_q[1:0], 3'b000} +: 8];
    half_sel  = o_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (size_q)
      SZ_BYTE: load_data = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      SZ_HALF: load_data = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state: accept instructions in IDLE, complete the access in ACCESS.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    o_d           = o_q;
    b_d           = b_q;
    size_d        = size_q;
    rw_d          = rw_q;
    sext_d        = sext_q;
    sel_d         = sel_q;
    dest_d        = dest_q;
    wr_d          = wr_q;
    wb_valid_d    = 1'b0;
    wb_pc_d       = wb_pc_q;
    wb_data_d     = wb_data_q;
    wb_dest_d     = wb_dest_q;
    wb_write_en_d = wb_write_en_q;
`ifdef IM_MISALIGN_TRAP_EN
    misalign_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (mem_en_in && !trap) begin
            pc_d    = pc_in;
            o_d     = O_in;
            b_d     = B_in;
            size_d  = access_size_in;
            rw_d    = rw_in;
            sext_d  = memory_sign_extend_in;
            sel_d   = res_data_sel_in;
            dest_d  = dest_reg_in;
            wr_d    = write_to_reg_in;
            state_d = ST_ACCESS;
          end else if (mem_en_in) begin
            // Trapped access: report it with the offending address, never write the RF.
            wb_valid_d    = 1'b1;
            wb_pc_d       = pc_in;
            wb_data_d     = O_in;
            wb_dest_d     = dest_reg_in;
            wb_write_en_d = 1'b0;
`ifdef IM_MISALIGN_TRAP_EN
            misalign_d    = 1'b1;
`endif
          end else begin
            wb_valid_d    = 1'b1;
            wb_pc_d       = pc_in;
            wb_data_d     = O_in;
            wb_dest_d     = dest_reg_in;
            wb_write_en_d = write_to_reg_in;
          end
        end
      end
      default: begin
        if (dmem_ready) begin
          wb_valid_d    = 1'b1;
          wb_pc_d       = pc_q;
          wb_data_d     = sel_q ? load_data : o_q;
          wb_dest_d     = dest_q;
          wb_write_en_d = wr_q;
          state_d       = ST_IDLE;
        end
      end
    endcase
  end

  // State, latched access and write-back registers; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      o_q           <= '0;
      b_q           <= '0;
      size_q        <= '0;
      rw_q          <= 1'b0;
      sext_q        <= 1'b0;
      sel_q         <= 1'b0;
      dest_q        <= '0;
      wr_q          <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_data_q     <= '0;
      wb_dest_q     <= '0;
      wb_write_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      o_q           <= o_d;
      b_q           <= b_d;
      size_q        <= size_d;
      rw_q          <= rw_d;
      sext_q        <= sext_d;
      sel_q         <= sel_d;
      dest_q        <= dest_d;
      wr_q          <= wr_d;
      wb_valid_q    <= wb_valid_d;
      wb_pc_q       <= wb_pc_d;
      wb_data_q     <= wb_data_d;
      wb_dest_q     <= wb_dest_d;
      wb_write_en_q <= wb_write_en_d;
    end
  end

`ifdef IM_MISALIGN_TRAP_EN
  // One-cycle misalignment flag, aligned with the trapped write-back record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`endif

  // Stall is gated by rst so it drops the moment reset is asserted.
  assign stall = !rst && ((state_q == ST_ACCESS) ? !dmem_ready
                                                 : (in_valid && mem_en_in && !trap));

  assign dmem_req    = (state_q == ST_ACCESS);
  assign dmem_we     = (state_q == ST_ACCESS) && rw_q;
  assign dmem_addr   = {o_q[31:2], 2'b00};
  assign dmem_be     = be;
  assign dmem_wdata  = wdata;

  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_pc_q;
  assign wb_data     = wb_data_q;
  assign wb_dest     = wb_dest_q;
  assign wb_write_en = wb_write_en_q;

endmodule

// File: tb/tb_im_stage_ctrl.sv
// Testbench for im_stage_ctrl: scoreboard of expected write-back records,
// one task per scenario. Honours IM_MISALIGN_TRAP_EN if defined for the build.
module tb_im_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc_in, O_in, B_in;
  logic [1:0]  access_size_in;
  logic        rw_in, mem_en_in, memory_sign_extend_in, res_data_sel_in;
  logic [4:0]  dest_reg_in;
  logic        write_to_reg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall, wb_valid;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_dest;
  logic        wb_write_en, misalign_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  dest;
    logic        we;
    logic        err;
  } wb_t;

  typedef struct {
    logic [31:0] o, b, rdata;
    logic [1:0]  size;
    logic        rw, sext, sel;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_data;
    int          delay;
  } mt_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  im_stage_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .O_in(O_in), .B_in(B_in),
    .access_size_in(access_size_in), .rw_in(rw_in), .mem_en_in(mem_en_in),
    .memory_sign_extend_in(memory_sign_extend_in), .res_data_sel_in(res_data_sel_in),
    .dest_reg_in(dest_reg_in), .write_to_reg_in(write_to_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_write_en(wb_write_en), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Present one instruction, hold it while stalled (scrambling operands once the
  // stage has latched them) and raise dmem_ready after ready_delay request cycles.
  task automatic issue(input logic [31:0] pc, input logic [31:0] o, input logic [31:0] b,
                       input logic [1:0] size, input logic rw, input logic mem_en,
                       input logic sext, input logic sel, input logic [4:0] dest,
                       input logic wr, input int ready_delay, input logic [31:0] rdata,
                       output int stall_cycles, output int req_cycles,
                       output logic [31:0] addr, output logic [3:0] be,
                       output logic [31:0] wdata, output logic we,
                       output bit unstable, output bit timeout);
    bit done;
    done = 0; stall_cycles = 0; req_cycles = 0; unstable = 0;
    addr = '0; be = '0; wdata = '0; we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; pc_in = pc; O_in = o; B_in = b; access_size_in = size; rw_in = rw;
    mem_en_in = mem_en; memory_sign_extend_in = sext; res_data_sel_in = sel;
    dest_reg_in = dest; write_to_reg_in = wr; dmem_rdata = rdata; dmem_ready = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        if (req_cycles == 0) begin
          addr = dmem_addr; be = dmem_be; wdata = dmem_wdata; we = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {addr, be, wdata, we}) begin
          unstable = 1;
        end
        req_cycles++;
      end
      if (stall === 1'b1) stall_cycles++;
      done = (stall === 1'b0);
      @(posedge clk); #1;
      if (!done) begin
        dmem_ready = (req_cycles >= ready_delay);
        pc_in = $urandom; O_in = $urandom; B_in = $urandom;
        access_size_in = 2'($urandom); rw_in = 1'($urandom); dest_reg_in = 5'($urandom);
      end
    end
    timeout = !done;
    in_valid = 1'b0; mem_en_in = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall, wb_valid, wb_write_en, misalign_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl req/stall/wbv/we/err=%b expected 00000",
               {dmem_req, stall, wb_valid, wb_write_en, misalign_err});
    end
    checks++;
    if ({wb_pc, wb_data, wb_dest} !== 69'b0) begin
      errors++;
      $display("FAIL reset_data pc=%h data=%h dest=%0d expected all 0", wb_pc, wb_data, wb_dest);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; mem_en_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_valid, stall, dmem_req} !== 3'b0) begin
      errors++;
      $display("FAIL post_reset_idle wbv/stall/req=%b expected 000", {wb_valid, stall, dmem_req});
    end
  endtask

  task automatic test_alu;
    int sc, rc; logic [31:0] a, wd; logic [3:0] be; logic we; bit un, to; wb_t e, got;
    sb.push_back('{pc: 32'h100, data: 32'h1234, dest: 5'd5, we: 1'b1, err: 1'b0});
    issue(32'h100, 32'h1234, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 0, 32'h0,
          sc, rc, a, be, wd, we, un, to);
    checks++;
    if (to || sc != 0 || rc != 0) begin
      errors++;
      $display("FAIL alu_nomem timeout=%0d stall_cycles=%0d req_cycles=%0d expected 0/0/0", to, sc, rc);
    end
    @(negedge clk); checks++;
    if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL alu_wb wb_valid=%b queued=%0d expected wb_valid=1", wb_valid, sb.size());
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front(); got = {wb_pc, wb_data, wb_dest, wb_write_en, misalign_err};
      if (got !== e) begin
        errors++;
        $display("FAIL alu_wb got pc=%h data=%h dest=%0d we=%b err=%b expected pc=%h data=%h dest=%0d we=%b err=%b",
                 got.pc, got.data, got.dest, got.we, got.err, e.pc, e.data, e.dest, e.we, e.err);
      end
    end
    @(negedge clk); checks++;
    if ({wb_valid, wb_pc, wb_data, wb_dest, wb_write_en} !== {1'b0, 32'h100, 32'h1234, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL alu_hold wbv=%b pc=%h data=%h dest=%0d we=%b expected 0/100/1234/5/1",
               wb_valid, wb_pc, wb_data, wb_dest, wb_write_en);
    end
  endtask

  task automatic test_byte_store;
    int sc, rc; logic [31:0] a, wd; logic [3:0] be; logic we; bit un, to; wb_t e, got;
    sb.push_back('{pc: 32'h104, data: 32'h1003, dest: 5'd0, we: 1'b0, err: 1'b0});
    issue(32'h104, 32'h1003, 32'h0000_00AB, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3, 32'h0,
          sc, rc, a, be, wd, we, un, to);
    checks++;
    if (to || sc != 4 || rc != 4) begin
      errors++;
      $display("FAIL bstore_stall timeout=%0d stall_cycles=%0d req_cycles=%0d expected 0/4/4", to, sc, rc);
    end
    checks++;
    if ({a, be, wd, we, un} !== {32'h1000, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bstore_bus addr=%h be=%b wdata=%h we=%b unstable=%0d expected 1000/1000/ababab ab/1/0",
               a, be, wd, we, un);
    end
    @(negedge clk); checks++;
    if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL bstore_wb wb_valid=%b queued=%0d expected wb_valid=1", wb_valid, sb.size());
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front(); got = {wb_pc, wb_data, wb_dest, wb_write_en, misalign_err};
      if (got !== e) begin
        errors++;
        $display("FAIL bstore_wb got pc=%h data=%h we=%b expected pc=%h data=%h we=%b",
                 got.pc, got.data, got.we, e.pc, e.data, e.we);
      end
    end
    @(negedge clk); checks++;
    if ({wb_valid, dmem_req} !== 2'b00) begin
      errors++;
      $display("FAIL bstore_pulse wbv/req=%b expected 00", {wb_valid, dmem_req});
    end
  endtask

  task automatic test_mem_table;
    mt_t tbl[10];
    int sc, rc; logic [31:0] a, wd; logic [3:0] be; logic we; bit un, to; wb_t e, got;
    tbl[0] = '{32'h2001, 32'h0, 32'h0000_8000, 2'b10, 1'b0, 1'b1, 1'b1, 32'h2000, 4'b0010, 32'h0, 32'hFFFF_FF80, 1};
    tbl[1] = '{32'h2001, 32'h0, 32'h0000_8000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h2000, 4'b0010, 32'h0, 32'h0000_0080, 2};
    tbl[2] = '{32'h2002, 32'h0, 32'h8001_0000, 2'b01, 1'b0, 1'b1, 1'b1, 32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 0};
    tbl[3] = '{32'h2000, 32'h0, 32'h0000_F00F, 2'b01, 1'b0, 1'b0, 1'b1, 32'h2000, 4'b0011, 32'h0, 32'h0000_F00F, 0};
    tbl[4] = '{32'h3000, 32'h0, 32'h1234_5678, 2'b00, 1'b0, 1'b1, 1'b1, 32'h3000, 4'b1111, 32'h0, 32'h1234_5678, 1};
    tbl[5] = '{32'h3008, 32'h0, 32'h8765_4321, 2'b11, 1'b0, 1'b1, 1'b1, 32'h3008, 4'b1111, 32'h0, 32'h8765_4321, 0};
    tbl[6] = '{32'h2002, 32'h1234_CDEF, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h2000, 4'b1100, 32'hCDEF_CDEF, 32'h2002, 2};
    tbl[7] = '{32'h3004, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h3004, 4'b1111, 32'hDEAD_BEEF, 32'h3004, 0};
    tbl[8] = '{32'h0001, 32'h0000_005A, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0000, 4'b0010, 32'h5A5A_5A5A, 32'h0001, 1};
    tbl[9] = '{32'h4002, 32'h0, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1, 1'b0, 32'h4000, 4'b0100, 32'h0, 32'h4002, 0};
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{pc: 32'h400 + 32'(4 * i), data: tbl[i].exp_data, dest: 5'(i + 1),
                     we: !tbl[i].rw, err: 1'b0});
      issue(32'h400 + 32'(4 * i), tbl[i].o, tbl[i].b, tbl[i].size, tbl[i].rw, 1'b1, tbl[i].sext,
            tbl[i].sel, 5'(i + 1), !tbl[i].rw, tbl[i].delay, tbl[i].rdata,
            sc, rc, a, be, wd, we, un, to);
      checks++;
      if (to || rc != tbl[i].delay + 1 || un) begin
        errors++;
        $display("FAIL tbl%0d_access timeout=%0d req_cycles=%0d unstable=%0d expected 0/%0d/0",
                 i, to, rc, un, tbl[i].delay + 1);
      end
      checks++;
      if ({a, be, we} !== {tbl[i].exp_addr, tbl[i].exp_be, tbl[i].rw}) begin
        errors++;
        $display("FAIL tbl%0d_bus addr=%h be=%b we=%b expected addr=%h be=%b we=%b",
                 i, a, be, we, tbl[i].exp_addr, tbl[i].exp_be, tbl[i].rw);
      end
      if (tbl[i].rw) begin
        checks++;
        if (wd !== tbl[i].exp_wdata) begin
          errors++;
          $display("FAIL tbl%0d_wdata wdata=%h expected %h", i, wd, tbl[i].exp_wdata);
        end
      end
      @(negedge clk); checks++;
      if (wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL tbl%0d_wb wb_valid=%b queued=%0d expected wb_valid=1", i, wb_valid, sb.size());
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front(); got = {wb_pc, wb_data, wb_dest, wb_write_en, misalign_err};
        if (got !== e) begin
          errors++;
          $display("FAIL tbl%0d_wb got pc=%h data=%h dest=%0d we=%b err=%b expected pc=%h data=%h dest=%0d we=%b err=%b",
                   i, got.pc, got.data, got.dest, got.we, got.err, e.pc, e.data, e.dest, e.we, e.err);
        end
      end
      @(negedge clk); checks++;
      if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL tbl%0d_pulse wb_valid=%b expected 0", i, wb_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    wb_t e, got;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_en_in = 1'b0; pc_in = 32'h500; O_in = 32'hAAAA; dest_reg_in = 5'd3;
    write_to_reg_in = 1'b1;
    sb.push_back('{pc: 32'h500, data: 32'hAAAA, dest: 5'd3, we: 1'b1, err: 1'b0});
    @(posedge clk); #1;
    pc_in = 32'h504; O_in = 32'hBBBB; dest_reg_in = 5'd4; write_to_reg_in = 1'b0;
    sb.push_back('{pc: 32'h504, data: 32'hBBBB, dest: 5'd4, we: 1'b0, err: 1'b0});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); checks++;
      if (wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL b2b%0d_wb wb_valid=%b queued=%0d expected wb_valid=1", k, wb_valid, sb.size());
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front(); got = {wb_pc, wb_data, wb_dest, wb_write_en, misalign_err};
        if (got !== e) begin
          errors++;
          $display("FAIL b2b%0d_wb got pc=%h data=%h dest=%0d we=%b expected pc=%h data=%h dest=%0d we=%b",
                   k, got.pc, got.data, got.dest, got.we, e.pc, e.data, e.dest, e.we);
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk); checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_ready_idle;
    @(posedge clk); #1;
    in_valid = 1'b0; dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); checks++;
      if ({wb_valid, dmem_req, stall} !== 3'b000) begin
        errors++;
        $display("FAIL ready_idle%0d wbv/req/stall=%b expected 000", k, {wb_valid, dmem_req, stall});
      end
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
  endtask

  task automatic test_misalign;
    int sc, rc; logic [31:0] a, wd; logic [3:0] be; logic we; bit un, to; wb_t e, got;
    logic [31:0] mo[2];
    logic [1:0]  ms[2];
    mo[0] = 32'h102; ms[0] = 2'b00;
    mo[1] = 32'h203; ms[1] = 2'b01;
    for (int k = 0; k < 2; k++) begin
`ifdef IM_MISALIGN_TRAP_EN
      sb.push_back('{pc: 32'h600 + 32'(4 * k), data: mo[k], dest: 5'd9, we: 1'b0, err: 1'b1});
`else
      sb.push_back('{pc: 32'h600 + 32'(4 * k), data: (k == 0) ? 32'hCAFE_F00D : 32'h0000_CAFE,
                     dest: 5'd9, we: 1'b1, err: 1'b0});
`endif
      issue(32'h600 + 32'(4 * k), mo[k], 32'h0, ms[k], 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 0,
            32'hCAFE_F00D, sc, rc, a, be, wd, we, un, to);
      checks++;
`ifdef IM_MISALIGN_TRAP_EN
      if (to || sc != 0 || rc != 0) begin
        errors++;
        $display("FAIL mis%0d_noreq timeout=%0d stall_cycles=%0d req_cycles=%0d expected 0/0/0",
                 k, to, sc, rc);
      end
`else
      if (to || rc != 1 || a !== {mo[k][31:2], 2'b00} || be !== ((k == 0) ? 4'b1111 : 4'b1100)) begin
        errors++;
        $display("FAIL mis%0d_access timeout=%0d req_cycles=%0d addr=%h be=%b", k, to, rc, a, be);
      end
`endif
      @(negedge clk); checks++;
      if (wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL mis%0d_wb wb_valid=%b queued=%0d expected wb_valid=1", k, wb_valid, sb.size());
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front(); got = {wb_pc, wb_data, wb_dest, wb_write_en, misalign_err};
        if (got !== e) begin
          errors++;
          $display("FAIL mis%0d_wb got pc=%h data=%h we=%b err=%b expected pc=%h data=%h we=%b err=%b",
                   k, got.pc, got.data, got.we, got.err, e.pc, e.data, e.we, e.err);
        end
      end
      @(negedge clk); checks++;
      if ({wb_valid, misalign_err} !== 2'b00) begin
        errors++;
        $display("FAIL mis%0d_pulse wbv/err=%b expected 00", k, {wb_valid, misalign_err});
      end
    end
  endtask

  task automatic test_reset_in_access;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_en_in = 1'b1; pc_in = 32'h700; O_in = 32'h1003; B_in = 32'hAB;
    access_size_in = 2'b10; rw_in = 1'b1; dest_reg_in = 5'd0; write_to_reg_in = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); checks++;
    if ({dmem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_acc_pre req/stall=%b expected 11", {dmem_req, stall});
    end
    #1 rst = 1'b1;
    #1 checks++;
    if ({dmem_req, stall, wb_valid, wb_data} !== 35'b0) begin
      errors++;
      $display("FAIL rst_acc_drop req=%b stall=%b wbv=%b data=%h expected 0/0/0/0",
               dmem_req, stall, wb_valid, wb_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; mem_en_in = 1'b0; dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); checks++;
      if ({wb_valid, dmem_req} !== 2'b00) begin
        errors++;
        $display("FAIL rst_acc_after%0d wbv/req=%b expected 00", k, {wb_valid, dmem_req});
      end
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; mem_en_in = 1'b1; pc_in = '0; O_in = '0; B_in = '0;
    access_size_in = '0; rw_in = 1'b0; memory_sign_extend_in = 1'b0; res_data_sel_in = 1'b0;
    dest_reg_in = '0; write_to_reg_in = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;
    test_reset();
    test_alu();
    test_byte_store();
    test_mem_table();
    test_back_to_back();
    test_ready_idle();
    test_misalign();
    test_reset_in_access();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty left=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/im_stage_ctrl.md
IM_STAGE_CTRL -- requirements
Module: im_stage_ctrl

Interface
REQ-001 SHALL use a single clock `clk`; all state updates occur on the posedge of `clk`.
REQ-002 SHALL have reset `rst`, asynchronous and active-high.
REQ-003 SHALL have these ports (clock and reset first; each line is name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- in_valid  in  1  IX/IM register holds a real instruction.
- pc_in  in  32  instruction PC.
- O_in  in  32  ALU result or effective address.
- B_in  in  32  store data.
- access_size_in  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- rw_in  in  1  0 read, 1 write.
- mem_en_in  in  1  instruction accesses data memory.
- memory_sign_extend_in  in  1  sign-extend loads.
- res_data_sel_in  in  1  0 write back O, 1 write back load data.
- dest_reg_in  in  5  destination register.
- write_to_reg_in  in  1  register-file write enable.
- dmem_req  out  1  memory request.
- dmem_we  out  1  memory write.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data.
- dmem_ready  in  1  access complete this cycle.
- stall  out  1  upstream shall hold.
- wb_valid  out  1  wb_* outputs valid this cycle.
- wb_pc  out  32  PC of the result.
- wb_data  out  32  write-back data.
- wb_dest  out  5  destination register.
- wb_write_en  out  1  register-file write.
- misalign_err  out  1  misaligned access trapped.

Function
REQ-004 SHALL implement FSM states IDLE and ACCESS.
REQ-005 IDLE, in_valid=1, mem_en_in=0: at the next edge load wb_* (wb_data=O_in, wb_write_en=write_to_reg_in) and set wb_valid=1; stall=0; 1-cycle latency.
REQ-006 IDLE, in_valid=1, mem_en_in=1: stall=1 combinationally; at the next edge latch all inputs, enter ACCESS, and set wb_valid=0.
REQ-007 ACCESS: dmem_req=1 and dmem_addr/we/be/wdata are driven from latched values, held stable until dmem_ready.
REQ-008 ACCESS: stall=!dmem_ready; inputs are not re-sampled while in ACCESS.
REQ-009 ACCESS with dmem_ready=1:
- at the edge load wb_*, pulse wb_valid for 1 cycle, and return to IDLE;
- wb_data = formatted load data if res_data_sel=1, else O.
REQ-010 in_valid=0 in IDLE: wb_valid=0 at the next edge; other wb_* hold.
REQ-011 dmem_addr = {O[31:2],2'b00}.
REQ-012 Byte lanes are little-endian:
- byte: be=1<<O[1:0], wdata={4{B[7:0]}};
- half: be=O[1]?1100:0011, wdata={2{B[15:0]}};
- word: be=1111, wdata=B.
REQ-013 Load data SHALL be the addressed byte/half of dmem_rdata (shifted by 8*O[1:0]), zero- or sign-extended per memory_sign_extend.
REQ-014 dmem_ready outside ACCESS SHALL be ignored.

Reset
REQ-015 On rst, state=IDLE, dmem_req=0, stall=0, wb_valid=0, wb_write_en=0, misalign_err=0, and all wb_* data=0, immediately and asynchronously.
REQ-016 Reset during ACCESS SHALL abandon the access with no write-back; the first post-reset edge behaves as IDLE.

Configuration
REQ-017 Macro IM_MISALIGN_TRAP_EN defined, misaligned access (half with O[0]=1, word with O[1:0]!=0):
- no memory request;
- at the next edge wb_valid=1, wb_write_en=0, misalign_err=1 for 1 cycle;
- stall=0.
REQ-018 IM_MISALIGN_TRAP_EN undefined: misalign_err is tied 0, and unused low address bits are ignored (half uses O[1] only, word ignores O[1:0]).

Verification
REQ-019 ALU op: O_in=0x1234, dest 5, write_to_reg=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_dest=5, no dmem_req.
REQ-020 Byte store: O=0x1003, B=0xAB, dmem_ready after 3 cycles -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, stall high 4 cycles, wb_valid one pulse.
REQ-021 Signed byte load: O=0x2001, rdata=0x00008000 -> wb_data=0xFFFFFF80; same with unsigned -> wb_data=0x00000080.
REQ-022 rst asserted in ACCESS -> dmem_req and stall drop at once, and no wb_valid follows.
REQ-023 With IM_MISALIGN_TRAP_EN: word load at O=0x102 -> no dmem_req, misalign_err=1, wb_write_en=0 for 1 cycle.
